unified_mem_arbiter: RTL and testbench
======================================

# unified_mem_arbiter

Shares one single-ported unified instruction/data memory between the pipeline's Fetch stage and Memory stage. It arbitrates per access, with the data side having priority, and runs a req/ready handshake to the memory. It captures returned words and drives stall signals so the pipelined processor freezes until its access has completed. It sits between the datapath (PCF, ALUResultM, WriteDataM) and the external memory model, alongside the control unit's MemWriteM/MemtoReg outputs.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data word width

- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- FetchReqF  in  1  Fetch wants an instruction at PCF (driver ties low while PCWrPendingF)
- PCF  in  ADDR_W  fetch address
- DataReqM  in  1  Memory stage access pending (MemWriteM | MemtoRegM)
- MemWriteM  in  1  1 = store, 0 = load; valid with DataReqM
- ALUResultM  in  ADDR_W  data address
- WriteDataM  in  DATA_W  store data
- InstrF  out  DATA_W  last captured instruction word
- ReadDataM  out  DATA_W  last captured load word
- StallF  out  1  freeze PC and F/D register
- StallM  out  1  freeze entire pipeline (F through M)
- MemReq  out  1  memory request
- MemWe  out  1  write enable
- MemAddr  out  ADDR_W  memory address
- MemWData  out  DATA_W  memory write data
- MemReady  in  1  memory completes transfer this cycle
- MemRData  in  DATA_W  read data, valid when MemReq & MemReady

## Operation
- States: IDLE, BUSY_D, BUSY_F. Done flags: data_done, fetch_done.
- IDLE grant, combinational:
  - If DataReqM & !data_done, grant data: MemReq=1, MemWe=MemWriteM, MemAddr=ALUResultM, MemWData=WriteDataM.
  - Otherwise, if FetchReqF & !fetch_done, grant fetch: MemReq=1, MemWe=0, MemAddr=PCF.
  - Otherwise, MemReq=0.
- On grant, the command is latched. In BUSY_x, the latched command drives the bus unchanged, with MemReq=1.
- Completion is any cycle with MemReq & MemReady:
  - Data read: ReadDataM <= MemRData.
  - Data write: ReadDataM holds.
  - Fetch: InstrF <= MemRData.
  - Set the matching done flag; next state is IDLE.
- Granted in IDLE with MemReady=0: next state is BUSY_D or BUSY_F.
- No preemption: an in-flight fetch finishes before a newly arriving data request is granted.
- StallM = DataReqM & !data_done.
- StallF = (FetchReqF & !fetch_done) | StallM.
- data_done clears on any cycle with !StallM (pipeline advances) or !DataReqM.
- fetch_done clears on any cycle with !StallF or !FetchReqF.
- If FetchReqF drops mid-transaction (branch redirect), the bus transfer still completes. InstrF is captured, but fetch_done clears next cycle, so the word is discarded.
- Addresses are passed through unmodified; there is no alignment check.

## Timing
- Reset (synchronous, takes effect at the clock edge):
  - State IDLE; data_done=0, fetch_done=0.
  - InstrF=0, ReadDataM=0.
  - Latched command is zero, so MemReq/MemWe/MemAddr/MemWData are 0 in the first post-reset cycle unless a grant occurs in IDLE.
- Reset mid-transaction: the request is abandoned and the memory side must tolerate this. Flags clear, so the pipeline re-requests.
- Zero-wait memory: an access granted in cycle N completes in N. Its stall drops in N+1 and the stage advances at the end of N+1. Each access costs 2 cycles.
- k wait cycles add k cycles. MemAddr/MemWe/MemWData must stay stable from grant to completion.
- Load followed by fetch: data completes in N. Fetch is granted in N+1 (data_done=1 masks re-issue), completes in N+1, and StallF=0 in N+2.
- Both requests in the same IDLE cycle: data wins. Fetch is granted in the first IDLE cycle with no ungranted data request.
- The done flag and captured word are visible the cycle after completion. InstrF/ReadDataM hold until the next completion of the same type.

## Structure
- Shared package: `arb_state_t` enum {IDLE, BUSY_D, BUSY_F}, and constant `ARB_DATA_PRIORITY = 1`.
- One sub-module, `en_res_ff`: synchronous-reset register with enable, parameterised width. It is used for the command latch, InstrF, and ReadDataM.

## Test plan
- Zero-wait fetch only: PCF=0x10, MemReady=1, MemRData=0xE2800001.
  - Required: MemReq in cycle 0, InstrF=0xE2800001 and StallF=0 in cycle 1.
- Load with 2 wait states: ALUResultM=0x80, MemRData=0xDEADBEEF.
  - Required: StallM=1 for 3 cycles, ReadDataM=0xDEADBEEF, MemAddr stable at 0x80 throughout.
- Simultaneous store (addr 0x40, data 0x55) and fetch (PCF=0x20).
  - Required: store is granted first with MemWe=1, then fetch is granted; ReadDataM unchanged.
- Fetch in BUSY_F, data request arrives.
  - Required: fetch completes first with no preemption, then data is granted; StallM stays 1 until data completes.
- FetchReqF dropped during a 3-wait fetch.
  - Required: transfer completes, fetch_done=0 afterward, no re-issue until FetchReqF rises.
- Reset asserted in BUSY_D.
  - Required: next cycle IDLE, flags 0, InstrF=ReadDataM=0, MemReq=0 when no requests.

Source files
------------

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified memory arbiter: FSM state encoding and grant policy.
// Data-side priority is a package constant so the fetch/data ordering is visible in one place.
package unified_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_D = 2'd1,
        BUSY_F = 2'd2
    } arb_state_t;

    localparam bit ARB_DATA_PRIORITY = 1'b1;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Pipeline-side (fetch/data) and memory-side signals of the unified memory arbiter.
// master = arbiter view; slave = the surrounding pipeline plus memory model.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              FetchReqF;
    logic [ADDR_W-1:0] PCF;
    logic              DataReqM;
    logic              MemWriteM;
    logic [ADDR_W-1:0] ALUResultM;
    logic [DATA_W-1:0] WriteDataM;
    logic [DATA_W-1:0] InstrF;
    logic [DATA_W-1:0] ReadDataM;
    logic              StallF;
    logic              StallM;
    logic              MemReq;
    logic              MemWe;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWData;
    logic              MemReady;
    logic [DATA_W-1:0] MemRData;

    modport master (
        input  FetchReqF, PCF, DataReqM, MemWriteM, ALUResultM, WriteDataM,
        input  MemReady, MemRData,
        output InstrF, ReadDataM, StallF, StallM,
        output MemReq, MemWe, MemAddr, MemWData
    );

    modport slave (
        output FetchReqF, PCF, DataReqM, MemWriteM, ALUResultM, WriteDataM,
        output MemReady, MemRData,
        input  InstrF, ReadDataM, StallF, StallM,
        input  MemReq, MemWe, MemAddr, MemWData
    );
endinterface

// File: rtl/unified_mem_arbiter_en_res_ff.sv
// Register with load enable and synchronous active-high clear; 1-cycle latency, holds while i_en=0.
module en_res_ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            o_q <= '0;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port memory shared by fetch and data; data wins in IDLE, no preemption once granted.
// Zero-wait access completes in its grant cycle; MemReady=0 holds the latched command and stalls.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    unified_mem_arbiter_if.master bus
);

    localparam int CMD_W = 1 + ADDR_W + DATA_W;

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              r_data_done;
    logic              r_fetch_done;

    logic              w_data_pend;
    logic              w_fetch_pend;
    logic              w_grant_d;
    logic              w_grant_f;
    logic              w_req;
    logic [CMD_W-1:0]  w_cmd;
    logic [CMD_W-1:0]  r_cmd;
    logic              w_cmd_we;
    logic [ADDR_W-1:0] w_cmd_addr;
    logic [DATA_W-1:0] w_cmd_wdata;
    logic              w_xfer;
    logic              w_cmp_d;
    logic              w_cmp_f;
    logic              w_stall_m;
    logic              w_stall_f;
    logic [DATA_W-1:0] w_instr;
    logic [DATA_W-1:0] w_rdata;

    assign w_data_pend  = bus.DataReqM  & ~r_data_done;
    assign w_fetch_pend = bus.FetchReqF & ~r_fetch_done;
    assign w_stall_m    = w_data_pend;
    assign w_stall_f    = w_fetch_pend | w_stall_m;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // In IDLE without a grant the bus shows the stale latched command with MemReq low.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_d   = 1'b0;
        w_grant_f   = 1'b0;
        w_req       = 1'b0;
        w_cmd       = r_cmd;
        case (r_state)
            IDLE: begin
                if (w_data_pend && (ARB_DATA_PRIORITY || !w_fetch_pend)) begin
                    w_grant_d = 1'b1;
                    w_req     = 1'b1;
                    w_cmd     = {bus.MemWriteM, bus.ALUResultM, bus.WriteDataM};
                    if (!bus.MemReady) begin
                        w_state_nxt = BUSY_D;
                    end
                end else if (w_fetch_pend) begin
                    w_grant_f = 1'b1;
                    w_req     = 1'b1;
                    w_cmd     = {1'b0, bus.PCF, {DATA_W{1'b0}}};
                    if (!bus.MemReady) begin
                        w_state_nxt = BUSY_F;
                    end
                end
            end
            BUSY_D, BUSY_F: begin
                w_req = 1'b1;
                if (bus.MemReady) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign {w_cmd_we, w_cmd_addr, w_cmd_wdata} = w_cmd;

    assign w_xfer  = w_req & bus.MemReady;
    assign w_cmp_d = w_xfer & (w_grant_d | (r_state == BUSY_D));
    assign w_cmp_f = w_xfer & (w_grant_f | (r_state == BUSY_F));

    en_res_ff #(.W(CMD_W)) u_cmd_latch (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_grant_d | w_grant_f),
        .i_d   (w_cmd),
        .o_q   (r_cmd)
    );

    en_res_ff #(.W(DATA_W)) u_instr (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_cmp_f),
        .i_d   (bus.MemRData),
        .o_q   (w_instr)
    );

    en_res_ff #(.W(DATA_W)) u_rdata (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_cmp_d & ~w_cmd_we),
        .i_d   (bus.MemRData),
        .o_q   (w_rdata)
    );

    // Done flags mask re-issue until the owning stage advances or withdraws its request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_done  <= 1'b0;
            r_fetch_done <= 1'b0;
        end else begin
            if (w_cmp_d) begin
                r_data_done <= 1'b1;
            end else if (!w_stall_m || !bus.DataReqM) begin
                r_data_done <= 1'b0;
            end
            if (w_cmp_f) begin
                r_fetch_done <= 1'b1;
            end else if (!w_stall_f || !bus.FetchReqF) begin
                r_fetch_done <= 1'b0;
            end
        end
    end

    assign bus.MemReq    = w_req;
    assign bus.MemWe     = w_cmd_we;
    assign bus.MemAddr   = w_cmd_addr;
    assign bus.MemWData  = w_cmd_wdata;
    assign bus.InstrF    = w_instr;
    assign bus.ReadDataM = w_rdata;
    assign bus.StallM    = w_stall_m;
    assign bus.StallF    = w_stall_f;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter; the memory side is driven cycle by cycle from the tasks.
module tb_unified_mem_arbiter;
    import unified_mem_arbiter_pkg::*;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.FetchReqF  = 1'b0;
        bus.PCF        = '0;
        bus.DataReqM   = 1'b0;
        bus.MemWriteM  = 1'b0;
        bus.ALUResultM = '0;
        bus.WriteDataM = '0;
        bus.MemReady   = 1'b0;
        bus.MemRData   = '0;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        total++; if (bus.MemReq !== 1'b0) begin bad++; $display("FAIL rst_memreq got=%0h want=0", bus.MemReq); end
        total++; if (bus.MemAddr !== 32'h0) begin bad++; $display("FAIL rst_memaddr got=%0h want=0", bus.MemAddr); end
        total++; if (bus.MemWe !== 1'b0) begin bad++; $display("FAIL rst_memwe got=%0h want=0", bus.MemWe); end
        total++; if (bus.InstrF !== 32'h0) begin bad++; $display("FAIL rst_instr got=%0h want=0", bus.InstrF); end
        total++; if (bus.ReadDataM !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%0h want=0", bus.ReadDataM); end
        total++; if ({bus.StallF, bus.StallM} !== 2'b00) begin bad++; $display("FAIL rst_stall got=%0b want=00", {bus.StallF, bus.StallM}); end
    endtask

    task automatic test_fetch_zero_wait;
        bus.FetchReqF = 1'b1;
        bus.PCF       = 32'h10;
        bus.MemReady  = 1'b1;
        bus.MemRData  = 32'hE280_0001;
        #1;
        total++; if (bus.MemReq !== 1'b1) begin bad++; $display("FAIL fz_req got=%0h want=1", bus.MemReq); end
        total++; if (bus.MemAddr !== 32'h10) begin bad++; $display("FAIL fz_addr got=%0h want=10", bus.MemAddr); end
        total++; if (bus.MemWe !== 1'b0) begin bad++; $display("FAIL fz_we got=%0h want=0", bus.MemWe); end
        total++; if (bus.StallF !== 1'b1) begin bad++; $display("FAIL fz_stall0 got=%0h want=1", bus.StallF); end
        tick();
        total++; if (bus.InstrF !== 32'hE280_0001) begin bad++; $display("FAIL fz_instr got=%0h want=e2800001", bus.InstrF); end
        total++; if (bus.StallF !== 1'b0) begin bad++; $display("FAIL fz_stall1 got=%0h want=0", bus.StallF); end
        total++; if (bus.MemReq !== 1'b0) begin bad++; $display("FAIL fz_noreissue got=%0h want=0", bus.MemReq); end
        idle_inputs();
        tick();
    endtask

    task automatic test_load_wait2;
        bus.DataReqM   = 1'b1;
        bus.MemWriteM  = 1'b0;
        bus.ALUResultM = 32'h80;
        bus.MemRData   = 32'hDEAD_BEEF;
        for (int c = 0; c < 3; c++) begin
            bus.MemReady = (c == 2);
            if (c > 0) bus.ALUResultM = 32'h84;
            #1;
            total++; if (bus.StallM !== 1'b1) begin bad++; $display("FAIL ld_stall c=%0d got=%0h want=1", c, bus.StallM); end
            total++; if (bus.MemReq !== 1'b1) begin bad++; $display("FAIL ld_req c=%0d got=%0h want=1", c, bus.MemReq); end
            total++; if (bus.MemAddr !== 32'h80) begin bad++; $display("FAIL ld_addr c=%0d got=%0h want=80", c, bus.MemAddr); end
            total++; if (bus.MemWe !== 1'b0) begin bad++; $display("FAIL ld_we c=%0d got=%0h want=0", c, bus.MemWe); end
            tick();
        end
        total++; if (bus.StallM !== 1'b0) begin bad++; $display("FAIL ld_stall_end got=%0h want=0", bus.StallM); end
        total++; if (bus.ReadDataM !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ld_rdata got=%0h want=deadbeef", bus.ReadDataM); end
        idle_inputs();
        tick();
    endtask

    task automatic test_store_and_fetch;
        bus.DataReqM   = 1'b1;
        bus.MemWriteM  = 1'b1;
        bus.ALUResultM = 32'h40;
        bus.WriteDataM = 32'h55;
        bus.FetchReqF  = 1'b1;
        bus.PCF        = 32'h20;
        bus.MemReady   = 1'b1;
        bus.MemRData   = 32'h1234_5678;
        #1;
        total++; if ({bus.MemReq, bus.MemWe} !== 2'b11) begin bad++; $display("FAIL sf_st_req_we got=%0b want=11", {bus.MemReq, bus.MemWe}); end
        total++; if (bus.MemAddr !== 32'h40) begin bad++; $display("FAIL sf_st_addr got=%0h want=40", bus.MemAddr); end
        total++; if (bus.MemWData !== 32'h55) begin bad++; $display("FAIL sf_st_wdata got=%0h want=55", bus.MemWData); end
        total++; if ({bus.StallF, bus.StallM} !== 2'b11) begin bad++; $display("FAIL sf_stall0 got=%0b want=11", {bus.StallF, bus.StallM}); end
        tick();
        total++; if ({bus.MemReq, bus.MemWe} !== 2'b10) begin bad++; $display("FAIL sf_f_req_we got=%0b want=10", {bus.MemReq, bus.MemWe}); end
        total++; if (bus.MemAddr !== 32'h20) begin bad++; $display("FAIL sf_f_addr got=%0h want=20", bus.MemAddr); end
        total++; if ({bus.StallF, bus.StallM} !== 2'b10) begin bad++; $display("FAIL sf_stall1 got=%0b want=10", {bus.StallF, bus.StallM}); end
        total++; if (bus.ReadDataM !== 32'hDEAD_BEEF) begin bad++; $display("FAIL sf_rdata_hold got=%0h want=deadbeef", bus.ReadDataM); end
        tick();
        bus.DataReqM = 1'b0;
        #1;
        total++; if (bus.InstrF !== 32'h1234_5678) begin bad++; $display("FAIL sf_instr got=%0h want=12345678", bus.InstrF); end
        total++; if ({bus.StallF, bus.MemReq} !== 2'b00) begin bad++; $display("FAIL sf_end got=%0b want=00", {bus.StallF, bus.MemReq}); end
        idle_inputs();
        tick();
    endtask

    task automatic test_no_preempt;
        bus.FetchReqF = 1'b1;
        bus.PCF       = 32'h30;
        bus.MemReady  = 1'b0;
        bus.MemRData  = 32'hAAAA_0001;
        #1;
        total++; if (bus.MemAddr !== 32'h30) begin bad++; $display("FAIL np_f_addr got=%0h want=30", bus.MemAddr); end
        tick();
        bus.DataReqM   = 1'b1;
        bus.MemWriteM  = 1'b0;
        bus.ALUResultM = 32'h90;
        bus.MemReady   = 1'b1;
        #1;
        total++; if (bus.MemAddr !== 32'h30) begin bad++; $display("FAIL np_busy_addr got=%0h want=30", bus.MemAddr); end
        total++; if (bus.StallM !== 1'b1) begin bad++; $display("FAIL np_stallm1 got=%0h want=1", bus.StallM); end
        tick();
        bus.MemRData = 32'hBBBB_0002;
        #1;
        total++; if (bus.InstrF !== 32'hAAAA_0001) begin bad++; $display("FAIL np_instr got=%0h want=aaaa0001", bus.InstrF); end
        total++; if (bus.MemAddr !== 32'h90) begin bad++; $display("FAIL np_d_addr got=%0h want=90", bus.MemAddr); end
        total++; if ({bus.StallF, bus.StallM} !== 2'b11) begin bad++; $display("FAIL np_stall2 got=%0b want=11", {bus.StallF, bus.StallM}); end
        tick();
        total++; if (bus.ReadDataM !== 32'hBBBB_0002) begin bad++; $display("FAIL np_rdata got=%0h want=bbbb0002", bus.ReadDataM); end
        total++; if ({bus.StallF, bus.StallM, bus.MemReq} !== 3'b000) begin bad++; $display("FAIL np_end got=%0b want=000", {bus.StallF, bus.StallM, bus.MemReq}); end
        idle_inputs();
        tick();
    endtask

    task automatic test_fetch_drop;
        bus.FetchReqF = 1'b1;
        bus.PCF       = 32'h50;
        bus.MemReady  = 1'b0;
        bus.MemRData  = 32'hCAFE_0003;
        #1;
        total++; if (bus.MemReq !== 1'b1) begin bad++; $display("FAIL fd_req0 got=%0h want=1", bus.MemReq); end
        tick();
        bus.FetchReqF = 1'b0;
        bus.PCF       = 32'h60;
        #1;
        total++; if ({bus.MemReq, bus.MemAddr} !== {1'b1, 32'h50}) begin bad++; $display("FAIL fd_busy got=%0h want=150", {bus.MemReq, bus.MemAddr}); end
        tick();
        tick();
        bus.MemReady = 1'b1;
        #1;
        total++; if ({bus.MemReq, bus.MemAddr} !== {1'b1, 32'h50}) begin bad++; $display("FAIL fd_done_cyc got=%0h want=150", {bus.MemReq, bus.MemAddr}); end
        tick();
        bus.MemReady = 1'b0;
        #1;
        total++; if (bus.InstrF !== 32'hCAFE_0003) begin bad++; $display("FAIL fd_instr got=%0h want=cafe0003", bus.InstrF); end
        total++; if ({bus.MemReq, bus.StallF} !== 2'b00) begin bad++; $display("FAIL fd_after got=%0b want=00", {bus.MemReq, bus.StallF}); end
        tick();
        total++; if (dut.r_fetch_done !== 1'b0) begin bad++; $display("FAIL fd_flag got=%0h want=0", dut.r_fetch_done); end
        total++; if (bus.MemReq !== 1'b0) begin bad++; $display("FAIL fd_noreissue got=%0h want=0", bus.MemReq); end
        tick();
        bus.FetchReqF = 1'b1;
        bus.PCF       = 32'h54;
        bus.MemReady  = 1'b1;
        #1;
        total++; if ({bus.MemReq, bus.MemAddr} !== {1'b1, 32'h54}) begin bad++; $display("FAIL fd_reissue got=%0h want=154", {bus.MemReq, bus.MemAddr}); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_busy;
        bus.DataReqM   = 1'b1;
        bus.MemWriteM  = 1'b0;
        bus.ALUResultM = 32'hA0;
        bus.MemReady   = 1'b0;
        #1;
        total++; if (bus.MemReq !== 1'b1) begin bad++; $display("FAIL rb_req got=%0h want=1", bus.MemReq); end
        tick();
        total++; if (dut.r_state !== BUSY_D) begin bad++; $display("FAIL rb_busy got=%0d want=%0d", dut.r_state, BUSY_D); end
        reset = 1'b1;
        idle_inputs();
        tick();
        reset = 1'b0;
        #1;
        total++; if (dut.r_state !== IDLE) begin bad++; $display("FAIL rb_state got=%0d want=%0d", dut.r_state, IDLE); end
        total++; if ({dut.r_data_done, dut.r_fetch_done} !== 2'b00) begin bad++; $display("FAIL rb_flags got=%0b want=00", {dut.r_data_done, dut.r_fetch_done}); end
        total++; if ({bus.InstrF, bus.ReadDataM} !== 64'h0) begin bad++; $display("FAIL rb_words got=%0h want=0", {bus.InstrF, bus.ReadDataM}); end
        total++; if ({bus.MemReq, bus.MemAddr} !== 33'h0) begin bad++; $display("FAIL rb_bus got=%0h want=0", {bus.MemReq, bus.MemAddr}); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_fetch_zero_wait();
        test_load_wait2();
        test_store_and_fetch();
        test_no_preempt();
        test_fetch_drop();
        test_reset_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
